// File: rtl/prandom_pkg.sv
// -----------------------------------------------------------------------------
// prandom_pkg
//   Shared definitions for the Prandom stream monitor:
//     PR_WIDTH  - default sample width of the Prandom Q output
//     state_t   - measurement FSM states (IDLE / RUN / DONE)
//     sat_inc   - saturating increment used by the bins and the run-length
//                 counter (callers widen to 32 bits and narrow the result)
// -----------------------------------------------------------------------------
package prandom_pkg;

    localparam int unsigned PR_WIDTH = 3;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    // Returns v+1, or vmax once v has reached vmax.
    function automatic logic [31:0] sat_inc(input logic [31:0] v,
                                            input logic [31:0] vmax);
        return (v >= vmax) ? vmax : v + 32'd1;
    endfunction

endpackage

// File: rtl/prandom_hist_bank.sv
// -----------------------------------------------------------------------------
// prandom_hist_bank
//   2**WIDTH saturating histogram counters with one registered read port.
//   Ports:
//     clk      in   rising-edge clock
//     clr      in   synchronous clear of all bins and of the read register
//     incr     in   increment bin[idx] this cycle
//     idx      in   bin to increment
//     rd_idx   in   bin to read
//     rd_data  out  bin[rd_idx] as it was before this edge (1-cycle latency)
// -----------------------------------------------------------------------------
module prandom_hist_bank
    import prandom_pkg::*;
#(
    parameter int unsigned WIDTH = PR_WIDTH,
    parameter int unsigned CNT_W = 16
) (
    input  logic             clk,
    input  logic             clr,
    input  logic             incr,
    input  logic [WIDTH-1:0] idx,
    input  logic [WIDTH-1:0] rd_idx,
    output logic [CNT_W-1:0] rd_data
);

    localparam int unsigned      NBINS   = 2**WIDTH;
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic [CNT_W-1:0] r_bins [NBINS];
    logic [CNT_W-1:0] r_rd;

    always_ff @(posedge clk) begin
        if (clr) begin
            for (int unsigned i = 0; i < NBINS; i++) begin
                r_bins[WIDTH'(i)] <= '0;
            end
            r_rd <= '0;
        end else begin
            // Read and increment on the same edge: the read sees the old count.
            r_rd <= r_bins[rd_idx];
            if (incr) begin
                r_bins[idx] <= CNT_W'(sat_inc(32'(r_bins[idx]), 32'(CNT_MAX)));
            end
        end
    end

    assign rd_data = r_rd;

endmodule

// File: rtl/prandom_monitor.sv
// -----------------------------------------------------------------------------
// prandom_monitor
//   Characterises the Prandom Q stream over a window of enabled samples:
//   per-value histogram, period to first recurrence of the reference sample,
//   and a sticky flag for a value repeated STUCK_LIM times in a row.
//   Ports:
//     clk           in   rising-edge clock
//     rst           in   synchronous active-high reset
//     en            in   q_in is a valid sample
//     q_in          in   sample from Prandom Q
//     clear         in   synchronous measurement restart (same as rst)
//     bin_sel       in   histogram bin to read
//     bin_count     out  bin[bin_sel], 1-cycle read latency
//     period        out  distance from reference to its first recurrence
//     period_valid  out  period holds a measured value
//     stuck         out  sticky stuck-value flag
//     done          out  window complete, results frozen
// -----------------------------------------------------------------------------
module prandom_monitor
    import prandom_pkg::*;
#(
    parameter int unsigned WIDTH     = PR_WIDTH,
    parameter int unsigned CNT_W     = 16,
    parameter int unsigned WINDOW    = 256,
    parameter int unsigned STUCK_LIM = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic [WIDTH-1:0] q_in,
    input  logic             clear,
    input  logic [WIDTH-1:0] bin_sel,
    output logic [CNT_W-1:0] bin_count,
    output logic [CNT_W-1:0] period,
    output logic             period_valid,
    output logic             stuck,
    output logic             done
);

    // Sample/since-ref counters are widened when WINDOW does not fit in CNT_W,
    // so the window still ends after exactly WINDOW samples; run length only
    // needs to count up to STUCK_LIM.
    localparam int unsigned SMP_W = (CNT_W > $clog2(WINDOW + 1)) ? CNT_W : $clog2(WINDOW + 1);
    localparam int unsigned RUN_W = $clog2(STUCK_LIM + 1);

    localparam logic [SMP_W-1:0] WIN_LAST = SMP_W'(WINDOW);
    localparam logic [CNT_W-1:0] PER_MAX  = '1;
    localparam logic [RUN_W-1:0] RUN_LIM  = RUN_W'(STUCK_LIM);

    state_t r_state, w_state_nxt;

    logic             w_clr;
    logic             w_first;
    logic             w_take;
    logic             w_match_prev;
    logic             w_match_ref;

    logic [WIDTH-1:0] r_ref;
    logic [WIDTH-1:0] r_prev;
    logic [SMP_W-1:0] r_sample_cnt;
    logic [SMP_W-1:0] w_sample_nxt;
    logic [SMP_W-1:0] r_since_ref;
    logic [SMP_W-1:0] w_since_nxt;
    logic [RUN_W-1:0] r_run_len;
    logic [RUN_W-1:0] w_run_nxt;
    logic [CNT_W-1:0] w_period_val;

    logic [CNT_W-1:0] r_period;
    logic             r_period_valid;
    logic             r_stuck;
    logic             r_done;

    assign w_clr        = rst | clear;
    assign w_first      = (r_state == IDLE) & en;
    assign w_take       = (r_state == RUN) & en;
    assign w_match_prev = (q_in == r_prev);
    assign w_match_ref  = (q_in == r_ref);

    // ---------------------------------------------------------------- FSM
    always_ff @(posedge clk) begin
        if (w_clr) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt  = r_state;
        w_sample_nxt = r_sample_cnt + SMP_W'(1);
        w_since_nxt  = r_since_ref + SMP_W'(1);
        w_run_nxt    = w_match_prev ? RUN_W'(sat_inc(32'(r_run_len), 32'(RUN_LIM)))
                                    : RUN_W'(1);
        // Period is clamped when it cannot be represented in CNT_W bits.
        w_period_val = (32'(w_since_nxt) > 32'(PER_MAX)) ? PER_MAX : CNT_W'(w_since_nxt);

        case (r_state)
            IDLE: begin
                if (en) begin
                    w_state_nxt = RUN;
                end
            end
            RUN: begin
                if (en && (w_sample_nxt == WIN_LAST)) begin
                    w_state_nxt = DONE;
                end
            end
            DONE: begin
                w_state_nxt = DONE;
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------ datapath
    always_ff @(posedge clk) begin
        if (w_clr) begin
            r_ref          <= '0;
            r_prev         <= '0;
            r_sample_cnt   <= '0;
            r_since_ref    <= '0;
            r_run_len      <= '0;
            r_period       <= '0;
            r_period_valid <= 1'b0;
            r_stuck        <= 1'b0;
            r_done         <= 1'b0;
        end else if (w_first) begin
            r_ref        <= q_in;
            r_prev       <= q_in;
            r_sample_cnt <= SMP_W'(1);
            r_since_ref  <= '0;
            r_run_len    <= RUN_W'(1);
        end else if (w_take) begin
            r_prev       <= q_in;
            r_sample_cnt <= w_sample_nxt;
            r_since_ref  <= w_since_nxt;
            r_run_len    <= w_run_nxt;
            if (w_run_nxt == RUN_LIM) begin
                r_stuck <= 1'b1;
            end
            if (!r_period_valid && w_match_ref) begin
                r_period       <= w_period_val;
                r_period_valid <= 1'b1;
            end
            // done rises on the same edge that takes the last window sample.
            if (w_sample_nxt == WIN_LAST) begin
                r_done <= 1'b1;
            end
        end
    end

    prandom_hist_bank #(
        .WIDTH (WIDTH),
        .CNT_W (CNT_W)
    ) u_hist (
        .clk     (clk),
        .clr     (w_clr),
        .incr    (w_first | w_take),
        .idx     (q_in),
        .rd_idx  (bin_sel),
        .rd_data (bin_count)
    );

    assign period       = r_period;
    assign period_valid = r_period_valid;
    assign stuck        = r_stuck;
    assign done         = r_done;

endmodule

// File: tb/tb_prandom_monitor.sv
// -----------------------------------------------------------------------------
// tb_prandom_monitor
//   Self-checking bench for prandom_monitor. Instance A uses WINDOW=16 with
//   16-bit counters; instance B uses CNT_W=2, WINDOW=8 to exercise saturation.
//   The reference model keeps the list of accepted samples since the last
//   restart and derives every result from that list.
// -----------------------------------------------------------------------------
module tb_prandom_monitor;

    localparam int WIN_A = 16;
    localparam int WIN_B = 8;
    localparam int MAX_A = 65535;
    localparam int MAX_B = 3;
    localparam int LIM   = 4;

    typedef struct {
        logic        en;
        logic        clr;
        logic [2:0]  q;
        logic [15:0] period;
        logic        pv;
        logic        stuck;
        logic        done;
    } vec_t;

    logic        clk = 1'b0;
    logic        rstA, enA, clrA;
    logic [2:0]  qA, bselA;
    logic [15:0] bcA, perA;
    logic        pvA, stA, dnA;
    logic        rstB, enB, clrB;
    logic [2:0]  qB, bselB;
    logic [1:0]  bcB, perB;
    logic        pvB, stB, dnB;

    int checks   = 0;
    int failures = 0;
    int hA[$];
    int hB[$];
    int expBcA, expBcB;

    always #5 clk = ~clk;

    prandom_monitor #(.WIDTH(3), .CNT_W(16), .WINDOW(WIN_A), .STUCK_LIM(LIM)) dutA (
        .clk(clk), .rst(rstA), .en(enA), .q_in(qA), .clear(clrA), .bin_sel(bselA),
        .bin_count(bcA), .period(perA), .period_valid(pvA), .stuck(stA), .done(dnA));

    prandom_monitor #(.WIDTH(3), .CNT_W(2), .WINDOW(WIN_B), .STUCK_LIM(LIM)) dutB (
        .clk(clk), .rst(rstB), .en(enB), .q_in(qB), .clear(clrB), .bin_sel(bselB),
        .bin_count(bcB), .period(perB), .period_valid(pvB), .stuck(stB), .done(dnB));

    // ------------------------------------------------------- reference model
    function automatic int m_bin(input int h[$], input int k, input int maxc);
        int c = 0;
        foreach (h[i]) if (h[i] == k) c++;
        return (c > maxc) ? maxc : c;
    endfunction

    function automatic int m_period(input int h[$], input int maxp);
        for (int i = 1; i < h.size(); i++)
            if (h[i] == h[0]) return (i > maxp) ? maxp : i;
        return 0;
    endfunction

    function automatic int m_pv(input int h[$]);
        for (int i = 1; i < h.size(); i++)
            if (h[i] == h[0]) return 1;
        return 0;
    endfunction

    function automatic int m_stuck(input int h[$]);
        int run = 0;
        for (int i = 0; i < h.size(); i++) begin
            run = (i > 0 && h[i] == h[i-1]) ? run + 1 : 1;
            if (run >= LIM) return 1;
        end
        return 0;
    endfunction

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
        end
    endtask

    // One clock: capture the expected read-port value, take the edge, then
    // apply the same inputs to the model.
    task automatic tick();
        expBcA = (rstA || clrA) ? 0 : m_bin(hA, int'(bselA), MAX_A);
        expBcB = (rstB || clrB) ? 0 : m_bin(hB, int'(bselB), MAX_B);
        @(posedge clk);
        #1;
        if (rstA || clrA) hA.delete();
        else if (enA && hA.size() < WIN_A) hA.push_back(int'(qA));
        if (rstB || clrB) hB.delete();
        else if (enB && hB.size() < WIN_B) hB.push_back(int'(qB));
    endtask

    task automatic checkA(input string tag);
        chk({tag, ".period"}, int'(perA), m_period(hA, MAX_A));
        chk({tag, ".pv"},     int'(pvA),  m_pv(hA));
        chk({tag, ".stuck"},  int'(stA),  m_stuck(hA));
        chk({tag, ".done"},   int'(dnA),  (hA.size() == WIN_A) ? 1 : 0);
        chk({tag, ".bin"},    int'(bcA),  expBcA);
    endtask

    task automatic zerosA(input string tag);
        chk({tag, ".period"}, int'(perA), 0);
        chk({tag, ".pv"},     int'(pvA),  0);
        chk({tag, ".stuck"},  int'(stA),  0);
        chk({tag, ".done"},   int'(dnA),  0);
        chk({tag, ".bin"},    int'(bcA),  0);
    endtask

    task automatic run_vec(input string tag, input vec_t v);
        enA  = v.en;
        clrA = v.clr;
        qA   = v.q;
        tick();
        chk({tag, ".period"}, int'(perA), int'(v.period));
        chk({tag, ".pv"},     int'(pvA),  int'(v.pv));
        chk({tag, ".stuck"},  int'(stA),  int'(v.stuck));
        chk({tag, ".done"},   int'(dnA),  int'(v.done));
    endtask

    task automatic restartA();
        enA  = 1'b0;
        clrA = 1'b1;
        tick();
        clrA = 1'b0;
    endtask

    logic [2:0] seq [7];
    int         t1bins [8];
    vec_t       t1 [16];
    vec_t       t2 [9];

    initial begin
        seq    = '{3'd1, 3'd2, 3'd5, 3'd3, 3'd7, 3'd6, 3'd4};
        t1bins = '{0, 3, 3, 2, 2, 2, 2, 2};
        for (int i = 0; i < 16; i++)
            t1[i] = '{1'b1, 1'b0, seq[i % 7], (i >= 7) ? 16'd7 : 16'd0,
                      (i >= 7), 1'b0, (i == 15)};
        t2 = '{'{1'b1, 1'b0, 3'd0, 16'd0, 1'b0, 1'b0, 1'b0},
               '{1'b1, 1'b0, 3'd0, 16'd1, 1'b1, 1'b0, 1'b0},
               '{1'b1, 1'b0, 3'd0, 16'd1, 1'b1, 1'b0, 1'b0},
               '{1'b1, 1'b0, 3'd0, 16'd1, 1'b1, 1'b1, 1'b0},
               '{1'b1, 1'b1, 3'd0, 16'd0, 1'b0, 1'b0, 1'b0},
               '{1'b1, 1'b0, 3'd0, 16'd0, 1'b0, 1'b0, 1'b0},
               '{1'b1, 1'b0, 3'd0, 16'd1, 1'b1, 1'b0, 1'b0},
               '{1'b1, 1'b0, 3'd0, 16'd1, 1'b1, 1'b0, 1'b0},
               '{1'b1, 1'b0, 3'd5, 16'd1, 1'b1, 1'b0, 1'b0}};

        rstA = 1'b1; enA = 1'b0; clrA = 1'b0; qA = '0; bselA = '0;
        rstB = 1'b1; enB = 1'b0; clrB = 1'b0; qB = '0; bselB = '0;
        repeat (3) tick();
        zerosA("reset");
        rstA = 1'b0;
        rstB = 1'b0;

        // Test 1: LFSR sequence, window of 16
        for (int i = 0; i < 16; i++) run_vec("t1", t1[i]);
        enA = 1'b0;
        for (int k = 0; k < 8; k++) begin
            bselA = 3'(k);
            tick();
            chk("t1.bin", int'(bcA), t1bins[k]);
        end
        chk("t1.done_hold", int'(dnA), 1);

        // Test 2: stuck detection
        restartA();
        for (int i = 0; i < 9; i++) run_vec("t2", t2[i]);
        restartA();
        for (int i = 0; i < WIN_A + 3; i++) begin
            enA = 1'b1;
            qA  = (i < 4) ? 3'd0 : 3'(i % 8);
            tick();
            checkA("t2.hold");
        end
        chk("t2.stuck_done", int'(stA), 1);

        // Test 3: saturation on instance B
        bselB = 3'd3;
        for (int i = 0; i < 10; i++) begin
            enB = 1'b1;
            qB  = 3'd3;
            tick();
            if (i == 6) chk("t3.done_early", int'(dnB), 0);
            if (i == 7) chk("t3.done", int'(dnB), 1);
        end
        enB = 1'b0;
        tick();
        chk("t3.bin3",   int'(bcB),  3);
        chk("t3.period", int'(perB), 1);
        chk("t3.pv",     int'(pvB),  1);
        chk("t3.stuck",  int'(stB),  1);

        // Test 4: en toggling, garbage q on idle cycles
        restartA();
        for (int i = 0; i < 32; i++) begin
            enA   = (i % 2 == 0);
            qA    = enA ? seq[(i / 2) % 7] : 3'd0;
            bselA = 3'(i % 8);
            tick();
            checkA("t4");
            if (i == 29) chk("t4.not_done", int'(dnA), 0);
        end
        chk("t4.period", int'(perA), 7);
        chk("t4.done",   int'(dnA),  1);

        // Test 5: clear with en mid-window
        restartA();
        for (int i = 0; i < 4; i++) begin
            enA = 1'b1;
            qA  = seq[i];
            tick();
            checkA("t5.pre");
        end
        clrA = 1'b1;
        qA   = 3'd7;
        tick();
        zerosA("t5.clear");
        clrA = 1'b0;
        qA = 3'd6; tick(); checkA("t5.ref");
        qA = 3'd1; tick(); checkA("t5.mid");
        qA = 3'd6; tick(); checkA("t5.rec");
        chk("t5.period", int'(perA), 2);

        // Test 6: rst mid-window and in DONE, read sweep
        restartA();
        for (int i = 0; i < 5; i++) begin
            enA = 1'b1;
            qA  = 3'($urandom_range(0, 7));
            tick();
        end
        rstA = 1'b1;
        tick();
        zerosA("t6.rst_mid");
        rstA = 1'b0;
        for (int i = 0; i < WIN_A; i++) begin
            enA = 1'b1;
            qA  = seq[(i + 3) % 7];
            tick();
        end
        chk("t6.done", int'(dnA), 1);
        for (int i = 0; i < 3; i++) begin
            qA = 3'd0;
            tick();
            checkA("t6.en_done");
        end
        enA = 1'b0;
        for (int k = 0; k < 8; k++) begin
            bselA = 3'(k);
            tick();
            checkA("t6.sweep");
        end
        rstA = 1'b1;
        tick();
        zerosA("t6.rst_done");
        rstA = 1'b0;

        // Randomized run against the model
        for (int i = 0; i < 400; i++) begin
            enA   = ($urandom_range(0, 3) != 0);
            clrA  = ($urandom_range(0, 49) == 0);
            rstA  = ($urandom_range(0, 99) == 0);
            qA    = ($urandom_range(0, 1) == 0) ? 3'($urandom_range(0, 1))
                                                : 3'($urandom_range(0, 7));
            bselA = 3'($urandom_range(0, 7));
            tick();
            checkA("rand");
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
